conv_seq: RTL

CONV_SEQ -- requirements
Module: conv_seq

---
 rtl/conv_seq_if.sv | 38 +++
 rtl/conv_seq.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/conv_seq_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | conv_seq_if : handshake, activation and coefficient-write bundle       |
// |               shared by conv_seq and its host.                         |
// | Revision    : 1.0                                                      |
// +-----------------------------------------------------------------------+
interface conv_seq_if #(
   parameter int IN_CH  = 3,
   parameter int KK     = 9,
   parameter int OUT_CH = 8,
   parameter int ACT_W  = 8,
   parameter int WGT_W  = 9
);
   localparam int TAPS = IN_CH * KK;
   localparam int AW   = $clog2(TAPS * OUT_CH + OUT_CH);

   logic                      in_valid;
   logic                      in_ready;
   logic [TAPS*ACT_W-1:0]     in_act;
   logic                      out_valid;
   logic                      out_ready;
   logic [OUT_CH*ACT_W-1:0]   out_act;
   logic                      cfg_we;
   logic [AW-1:0]             cfg_addr;
   logic [WGT_W-1:0]          cfg_data;
   logic                      busy;

   modport master (
      output in_valid, in_act, out_ready, cfg_we, cfg_addr, cfg_data,
      input  in_ready, out_valid, out_act, busy
   );

   modport slave (
      input  in_valid, in_act, out_ready, cfg_we, cfg_addr, cfg_data,
      output in_ready, out_valid, out_act, busy
   );
endinterface
`default_nettype wire

// File: rtl/conv_seq.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | conv_seq : sequential conv MAC, one tap per cycle across OUT_CH lanes, |
// |            bias + shift + clamp. Define CONV_SEQ_RELU_EN for ReLU-N.   |
// | Revision : 1.0                                                         |
// +-----------------------------------------------------------------------+
module conv_seq #(
   parameter int IN_CH   = 3,
   parameter int KK      = 9,
   parameter int OUT_CH  = 8,
   parameter int ACT_W   = 8,
   parameter int WGT_W   = 9,
   parameter int ACC_W   = 32,
   parameter int SHIFT   = 7,
   parameter int ACT_MAX = 6
) (
   input wire logic   clk,
   input wire logic   rst,
   conv_seq_if.slave  bus
);
   localparam int TAPS = IN_CH * KK;
   localparam int AW   = $clog2(TAPS * OUT_CH + OUT_CH);
   localparam int TW   = (TAPS > 1) ? $clog2(TAPS) : 1;
   localparam int PW   = WGT_W + ACT_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      POST = 2'd2,
      OUT  = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic [TW-1:0]           tap_q, tap_d;
   logic [TAPS*ACT_W-1:0]   act_q, act_d;
   logic signed [WGT_W-1:0] wgt_q  [TAPS][OUT_CH];
   logic signed [WGT_W-1:0] bias_q [OUT_CH];

   logic                    accept;
   logic                    cfg_wr;
   logic signed [ACT_W-1:0] act_cur;

   assign accept  = bus.in_valid && (state_q == IDLE);
   assign cfg_wr  = bus.cfg_we && (state_q == IDLE);
   // Activations shift down one tap per MAC cycle, so the current tap is always the LSBs.
   assign act_cur = act_q[ACT_W-1:0];

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.out_valid = (state_q == OUT);

   always_comb begin
      state_d = state_q;
      tap_d   = tap_q;
      act_d   = act_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = MAC;
               tap_d   = '0;
               act_d   = bus.in_act;
            end
         end
         MAC: begin
            act_d = act_q >> ACT_W;
            tap_d = tap_q + TW'(1);
            if (tap_q == TW'(TAPS - 1)) begin
               state_d = POST;
               tap_d   = '0;
            end
         end
         POST:    state_d = OUT;
         OUT:     if (bus.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         tap_q   <= '0;
         act_q   <= '0;
      end else begin
         state_q <= state_d;
         tap_q   <= tap_d;
         act_q   <= act_d;
      end
   end

   // Coefficient storage is deliberately left out of reset.
   for (genvar t = 0; t < TAPS; t++) begin : g_wt
      for (genvar c = 0; c < OUT_CH; c++) begin : g_wc
         always_ff @(posedge clk) begin
            if (cfg_wr && (bus.cfg_addr == AW'(t * OUT_CH + c)))
               wgt_q[t][c] <= bus.cfg_data;
         end
      end
   end

   for (genvar c = 0; c < OUT_CH; c++) begin : g_bias
      always_ff @(posedge clk) begin
         if (cfg_wr && (bus.cfg_addr == AW'(TAPS * OUT_CH + c)))
            bias_q[c] <= bus.cfg_data;
      end
   end

`ifdef CONV_SEQ_RELU_EN
   localparam logic signed [ACC_W-1:0] MAX_A  = ACC_W'(ACT_MAX);
`else
   localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(2 ** (ACT_W - 1) - 1);
   localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-(2 ** (ACT_W - 1)));
`endif

   for (genvar c = 0; c < OUT_CH; c++) begin : g_lane
      logic signed [ACC_W-1:0] acc_q, acc_d;
      logic signed [ACC_W-1:0] sum;
      logic signed [ACC_W-1:0] y;
      logic signed [PW-1:0]    prod;
      logic [ACT_W-1:0]        out_q, out_d;

      always_comb begin
         prod  = wgt_q[tap_q][c] * act_cur;
         sum   = acc_q + {{(ACC_W - WGT_W){bias_q[c][WGT_W-1]}}, bias_q[c]};
         y     = sum >>> SHIFT;
         acc_d = acc_q;
         out_d = out_q;
         if (accept)
            acc_d = '0;
         else if (state_q == MAC)
            acc_d = acc_q + {{(ACC_W - PW){prod[PW-1]}}, prod};
         if (state_q == POST) begin
`ifdef CONV_SEQ_RELU_EN
            if (y[ACC_W-1])
               out_d = '0;
            else if (y > MAX_A)
               out_d = MAX_A[ACT_W-1:0];
            else
               out_d = y[ACT_W-1:0];
`else
            if (y > SAT_HI)
               out_d = SAT_HI[ACT_W-1:0];
            else if (y < SAT_LO)
               out_d = SAT_LO[ACT_W-1:0];
            else
               out_d = y[ACT_W-1:0];
`endif
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            acc_q <= '0;
            out_q <= '0;
         end else begin
            acc_q <= acc_d;
            out_q <= out_d;
         end
      end

      assign bus.out_act[c*ACT_W +: ACT_W] = out_q;
   end
endmodule
`default_nettype wire
